// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-style bus responder with busy model and 80-char DDRAM.
// Define LCD_TIMING_CHECK_EN to reject writes whose e-high width is below E_MIN_CYC.
module lcd_bus_responder #(
    parameter int DEPTH     = 80,
    parameter int E_MIN_CYC = 12,
    parameter int CMD_CYC   = 2000,
    parameter int CLEAR_CYC = 76500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       rs,
    input  logic       rw,
    input  logic       e,
    output logic       busy_f,
    output logic [7:0] rd_data,
    output logic [6:0] ac,
    input  logic [6:0] peek_addr,
    output logic [7:0] peek_char,
    output logic       proto_err,
    output logic       timing_err
);
    localparam int CW = $clog2(CLEAR_CYC + CMD_CYC + 1);
    localparam logic [6:0] LAST = 7'(DEPTH - 1);
    typedef enum logic [1:0] {IDLE, BUSY, CLEARING} state_t;
    state_t state, state_n;
    logic e_s1, e_sync, e_prev, fall, ok;
    logic [7:0] d_lat, wdata;
    logic rs_lat, rw_lat, id_inc, id_inc_n, init, init_n, proto_n, timing_n, we;
    logic [CW-1:0] cnt, cnt_n;
    logic [6:0] ac_n, waddr;
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk or posedge rst)
        if (rst) {e_s1, e_sync, e_prev} <= '0;
        else {e_s1, e_sync, e_prev} <= {e, e_s1, e_sync};
    // bus is latched every cycle e_sync is high, so the last copy is the one from just before the fall
    always_ff @(posedge clk or posedge rst)
        if (rst) {d_lat, rs_lat, rw_lat} <= '0;
        else if (e_sync) {d_lat, rs_lat, rw_lat} <= {data, rs, rw};
    assign fall = e_prev & ~e_sync;
`ifdef LCD_TIMING_CHECK_EN
    localparam int WW = $clog2(E_MIN_CYC + 1);
    logic [WW-1:0] wcnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) wcnt <= '0;
        else if (!e_sync) wcnt <= '0;
        else if (wcnt != WW'(E_MIN_CYC)) wcnt <= wcnt + 1'b1;
    assign ok = wcnt == WW'(E_MIN_CYC);
`else
    assign ok = E_MIN_CYC >= 0;
`endif
    assign busy_f = state != IDLE;
    assign rd_data = e_sync && rw ? (rs ? mem[ac] : {busy_f, ac}) : 8'h00;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        ac_n = ac;
        id_inc_n = id_inc;
        init_n = init;
        proto_n = 1'b0;
        timing_n = 1'b0;
        we = 1'b0;
        waddr = ac;
        wdata = d_lat;
        case (state)
            IDLE: if (init) begin
                state_n = CLEARING;
                cnt_n = '0;
                init_n = 1'b0;
            end
            BUSY: if (cnt <= CW'(1)) state_n = IDLE;
                  else cnt_n = cnt - 1'b1;
            CLEARING: begin
                we = 1'b1;
                waddr = cnt[6:0];
                wdata = 8'h20;
                if (cnt == CW'(DEPTH - 1)) begin
                    state_n = CLEAR_CYC > DEPTH ? BUSY : IDLE;
                    cnt_n = CW'(CLEAR_CYC - DEPTH);
                end else cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (fall && !rw_lat && !ok) timing_n = 1'b1;
        else if (fall && !rw_lat && (busy_f || init)) proto_n = 1'b1;
        else if (fall && !rw_lat && rs_lat) begin
            we = 1'b1;
            waddr = ac;
            wdata = d_lat;
            ac_n = id_inc ? (ac == LAST ? 7'd0 : ac + 7'd1) : (ac == 7'd0 ? LAST : ac - 7'd1);
            state_n = BUSY;
            cnt_n = CW'(CMD_CYC);
        end else if (fall && !rw_lat) begin
            if (d_lat[7]) ac_n = d_lat[6:0] > LAST ? 7'd0 : d_lat[6:0];
            else if (d_lat[7:2] == 6'b000001) id_inc_n = d_lat[1];
            else if (d_lat[7:1] == 7'b0000001) ac_n = 7'd0;
            else if (d_lat == 8'h01) begin
                ac_n = 7'd0;
                id_inc_n = 1'b1;
            end
            state_n = d_lat == 8'h01 ? CLEARING : BUSY;
            cnt_n = d_lat == 8'h01 ? '0 : CW'(CMD_CYC);
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            ac <= '0;
            id_inc <= 1'b1;
            init <= 1'b1;
            proto_err <= 1'b0;
            timing_err <= 1'b0;
            peek_char <= 8'h00;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            ac <= ac_n;
            id_inc <= id_inc_n;
            init <= init_n;
            proto_err <= proto_n;
            timing_err <= timing_n;
            peek_char <= peek_addr <= LAST ? mem[peek_addr] : 8'h00;
        end
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb_lcd_bus_responder: directed bench for lcd_bus_responder with small busy timings.
`timescale 1ns/1ps
module tb_lcd_bus_responder;
    logic clk = 1'b0, rst = 1'b1, rs = 1'b0, rw = 1'b0, e = 1'b0;
    logic [7:0] data = 8'h00;
    logic [6:0] peek_addr = 7'd0;
    logic busy_f, proto_err, timing_err;
    logic [7:0] rd_data, peek_char, v;
    logic [6:0] ac;
    logic [1:0] bs;
    int n_cmp = 0, n_bad = 0, t_cnt = 0, p_cnt = 0, t0, p0, lat, len;

    lcd_bus_responder #(.DEPTH(80), .E_MIN_CYC(12), .CMD_CYC(20), .CLEAR_CYC(100)) dut (
        .clk(clk), .rst(rst), .data(data), .rs(rs), .rw(rw), .e(e),
        .busy_f(busy_f), .rd_data(rd_data), .ac(ac), .peek_addr(peek_addr),
        .peek_char(peek_char), .proto_err(proto_err), .timing_err(timing_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) begin
        t_cnt += int'(timing_err);
        p_cnt += int'(proto_err);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bus held for 3 cycles after e falls; b = busy_f sampled 2 and 3 cycles after the fall
    task automatic strobe(input logic r, input logic [7:0] d, input int hi, output logic [1:0] b);
        @(negedge clk); rs = r; rw = 1'b0; data = d; e = 1'b1;
        repeat (hi) @(negedge clk);
        e = 1'b0;
        repeat (2) @(negedge clk);
        b[1] = busy_f;
        @(negedge clk);
        b[0] = busy_f;
    endtask

    task automatic xfer(input logic r, input logic [7:0] d, input int hi, input int exp_len, input string tag);
        logic [1:0] b;
        int n;
        strobe(r, d, hi, b);
        if (exp_len > 0) begin
            check({tag, "_rise"}, 32'(b), 32'b01);
            n = 0;
            while (busy_f && n < 300) begin @(negedge clk); n++; end
            check({tag, "_len"}, n, exp_len);
        end else begin
            repeat (7) @(negedge clk);
            check({tag, "_nobusy"}, 32'({b, busy_f}), 32'b000);
        end
    endtask

    task automatic peek(input int a, output logic [7:0] q);
        @(negedge clk); peek_addr = 7'(a);
        @(negedge clk); q = peek_char;
    endtask

    task automatic check_fill(input string tag);
        logic [7:0] q;
        int bad = 0;
        for (int i = 0; i < 80; i++) begin
            peek(i, q);
            if (q !== 8'h20) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy_f && k < 500) begin @(negedge clk); k++; end
        check(tag, 32'(busy_f), 0);
    endtask

    task automatic bus_read(input logic r, output logic [7:0] q);
        @(negedge clk); rs = r; rw = 1'b1; e = 1'b1;
        repeat (3) @(negedge clk);
        q = rd_data;
        e = 1'b0;
        repeat (3) @(negedge clk);
        rw = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset values, then the init clear
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_f), 0);
        check("rst_ac", 32'(ac), 0);
        check("rst_rd", 32'(rd_data), 0);
        check("rst_peek", 32'(peek_char), 0);
        check("rst_err", 32'({proto_err, timing_err}), 0);
        rst = 1'b0;
        lat = 0;
        while (!busy_f && lat < 10) begin @(negedge clk); lat++; end
        len = 0;
        while (busy_f && len < 300) begin @(negedge clk); len++; end
        check("init_lat", lat, 1);
        check("init_len", len, 100);
        check_fill("init_fill");
        check("init_ac", 32'(ac), 0);
        // 2: clear display
        xfer(1'b0, 8'h01, 20, 100, "clr");
        check("clr_ac", 32'(ac), 0);
        check_fill("clr_fill");
        // 3: "180"
        xfer(1'b1, 8'h31, 20, 20, "d31");
        xfer(1'b1, 8'h38, 20, 20, "d38");
        xfer(1'b1, 8'h30, 20, 20, "d30");
        peek(0, v); check("dd0", 32'(v), 32'h31);
        peek(1, v); check("dd1", 32'(v), 32'h38);
        peek(2, v); check("dd2", 32'(v), 32'h30);
        check("ac3", 32'(ac), 3);
        // 4: wrap both ways
        xfer(1'b0, 8'hCF, 20, 20, "set79");
        check("ac79", 32'(ac), 79);
        xfer(1'b1, 8'h41, 20, 20, "d41");
        peek(79, v); check("dd79", 32'(v), 32'h41);
        check("ac_wrap_up", 32'(ac), 0);
        xfer(1'b0, 8'h04, 20, 20, "ent_dec");
        xfer(1'b1, 8'h42, 20, 20, "d42");
        peek(0, v); check("dd0_42", 32'(v), 32'h42);
        check("ac_wrap_dn", 32'(ac), 79);
        xfer(1'b0, 8'hE4, 20, 20, "set100");
        check("ac_oob", 32'(ac), 0);
        xfer(1'b0, 8'h85, 20, 20, "set5");
        check("ac5", 32'(ac), 5);
        xfer(1'b0, 8'h02, 20, 20, "home");
        check("ac_home", 32'(ac), 0);
        xfer(1'b0, 8'h85, 20, 20, "set5b");
        xfer(1'b0, 8'h06, 20, 20, "ent_inc");
        // 5: write during busy is dropped with proto_err; reads
        p0 = p_cnt;
        strobe(1'b1, 8'h55, 12, bs);
        check("d55_rise", 32'(bs), 32'b01);
        strobe(1'b1, 8'h77, 12, bs);
        wait_idle("proto_idle");
        check("proto_pulse", p_cnt - p0, 1);
        check("proto_ac", 32'(ac), 6);
        peek(5, v); check("dd5", 32'(v), 32'h55);
        peek(6, v); check("dd6", 32'(v), 32'h20);
        strobe(1'b0, 8'h0C, 20, bs);
        bus_read(1'b0, v);
        check("rd_busy", 32'(v), 32'h86);
        wait_idle("rd_idle");
        bus_read(1'b0, v);
        check("rd_idle_ac", 32'(v), 32'h06);
        bus_read(1'b1, v);
        check("rd_ddram", 32'(v), 32'h20);
        check("rd_no_e", 32'(rd_data), 0);
        check("rd_ac_same", 32'(ac), 6);
        // 6: short e-high width, then reset in BUSY and in CLEARING
        t0 = t_cnt;
`ifdef LCD_TIMING_CHECK_EN
        xfer(1'b0, 8'h01, 5, 0, "short_e");
        check("short_terr", t_cnt - t0, 1);
        check("short_ac", 32'(ac), 6);
`else
        xfer(1'b0, 8'h01, 5, 100, "short_e");
        check("short_terr", t_cnt - t0, 0);
        check("short_ac", 32'(ac), 0);
`endif
        strobe(1'b1, 8'h99, 20, bs);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(busy_f), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_busy_mid", 32'(busy_f), 0);
        check("rst_ac_mid", 32'(ac), 0);
        @(negedge clk); rst = 1'b0;
        repeat (30) @(negedge clk);
        check("reinit_busy", 32'(busy_f), 1);
        #1 rst = 1'b1;
        #1;
        check("rst_clr_busy", 32'(busy_f), 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        wait_idle("reinit_idle");
        check("reinit_ac", 32'(ac), 0);
        check_fill("reinit_fill");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
